// File: rtl/carry_select_adder.sv
// Registered carry-select adder: {cout, sum} = a + b + cin, one result per clock.
// Define CSA_INPUT_REG_EN to add an input register stage (latency 2 instead of 1).
module carry_select_adder #(
    parameter int WIDTH = 6,
    parameter int BLK   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
);

    localparam int NBLK = WIDTH / BLK;

    // Ripple of full adders; result is {carry_out, sum_bits}.
    function automatic logic [BLK:0] ripple_add(input logic [BLK-1:0] x,
                                                input logic [BLK-1:0] y,
                                                input logic           ci);
        logic           c;
        logic [BLK-1:0] s;
        c = ci;
        s = '0;
        for (int i = 0; i < BLK; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, s};
    endfunction

    logic [WIDTH-1:0] a_s;
    logic [WIDTH-1:0] b_s;
    logic             cin_s;
    logic             valid_s;

`ifdef CSA_INPUT_REG_EN
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             cin_q, cin_d;
    logic             in_valid_q, in_valid_d;

    always_comb begin
        a_d        = a;
        b_d        = b;
        cin_d      = cin;
        in_valid_d = in_valid;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            in_valid_q <= 1'b0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            cin_q      <= cin_d;
            in_valid_q <= in_valid_d;
        end
    end

    assign a_s     = a_q;
    assign b_s     = b_q;
    assign cin_s   = cin_q;
    assign valid_s = in_valid_q;
`else
    assign a_s     = a;
    assign b_s     = b;
    assign cin_s   = cin;
    assign valid_s = in_valid;
`endif

    logic [NBLK:0]    blk_carry;
    logic [WIDTH-1:0] comb_sum;

    assign blk_carry[0] = cin_s;

    // Upper blocks precompute both carry-in cases so only a mux sits on the carry chain.
    for (genvar k = 0; k < NBLK; k++) begin : g_blk
        if (k == 0) begin : g_ripple
            assign {blk_carry[1], comb_sum[BLK-1:0]} =
                ripple_add(a_s[BLK-1:0], b_s[BLK-1:0], blk_carry[0]);
        end else begin : g_select
            logic [BLK:0] cand0;
            logic [BLK:0] cand1;
            assign cand0 = ripple_add(a_s[k*BLK +: BLK], b_s[k*BLK +: BLK], 1'b0);
            assign cand1 = ripple_add(a_s[k*BLK +: BLK], b_s[k*BLK +: BLK], 1'b1);
            assign {blk_carry[k+1], comb_sum[k*BLK +: BLK]} = blk_carry[k] ? cand1 : cand0;
        end
    end

    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             out_valid_q, out_valid_d;

    always_comb begin
        sum_d       = sum_q;
        cout_d      = cout_q;
        out_valid_d = valid_s;
        if (valid_s) begin
            sum_d  = comb_sum;
            cout_d = blk_carry[NBLK];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_carry_select_adder.sv
// Self-checking bench for carry_select_adder: table vectors, hold/reset sequences,
// exhaustive sweep and random traffic against an arithmetic model (follows CSA_INPUT_REG_EN).
module tb_carry_select_adder;

`ifdef CSA_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk;
    logic       rst_n;
    logic [5:0] a;
    logic [5:0] b;
    logic       cin;
    logic       in_valid;
    logic [5:0] sum;
    logic       cout;
    logic       out_valid;

    int test_count = 0;
    int fail_count = 0;

    carry_select_adder #(.WIDTH(6), .BLK(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .sum       (sum),
        .cout      (cout),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [5:0] a;
        logic [5:0] b;
        logic       ci;
    } in_t;

    typedef struct {
        logic [5:0] a;
        logic [5:0] b;
        logic       ci;
        logic [5:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    in_t        pipe[$];
    logic [5:0] exp_sum;
    logic       exp_cout;
    logic       exp_valid;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        in_t blank;
        blank = '{v: 1'b0, a: 6'd0, b: 6'd0, ci: 1'b0};
        pipe.delete();
        for (int i = 0; i < LAT - 1; i++) pipe.push_back(blank);
        exp_sum   = '0;
        exp_cout  = 1'b0;
        exp_valid = 1'b0;
    endtask

    // Model the effect of one rising edge, using the inputs presented to it.
    task automatic model_edge();
        in_t        cur;
        in_t        head;
        logic [6:0] full;
        if (!rst_n) begin
            model_reset();
        end else begin
            cur = '{v: in_valid, a: a, b: b, ci: cin};
            pipe.push_back(cur);
            head      = pipe.pop_front();
            exp_valid = head.v;
            if (head.v) begin
                full     = 7'(head.a) + 7'(head.b) + 7'(head.ci);
                exp_sum  = full[5:0];
                exp_cout = full[6];
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_output("model_sum", 32'(sum), 32'(exp_sum));
        check_output("model_cout", 32'(cout), 32'(exp_cout));
        check_output("model_valid", 32'(out_valid), 32'(exp_valid));
    endtask

    task automatic apply_stimulus(input logic v, input logic [5:0] av,
                                  input logic [5:0] bv, input logic ci);
        in_valid = v;
        a        = av;
        b        = bv;
        cin      = ci;
    endtask

    vec_t vecs[7];
    logic stop;

    initial begin
        vecs[0] = '{a: 6'd63, b: 6'd1,  ci: 1'b0, exp_sum: 6'd0,  exp_cout: 1'b1};
        vecs[1] = '{a: 6'd63, b: 6'd63, ci: 1'b1, exp_sum: 6'd63, exp_cout: 1'b1};
        vecs[2] = '{a: 6'd47, b: 6'd31, ci: 1'b1, exp_sum: 6'd15, exp_cout: 1'b1};
        vecs[3] = '{a: 6'd47, b: 6'd19, ci: 1'b0, exp_sum: 6'd2,  exp_cout: 1'b1};
        vecs[4] = '{a: 6'd0,  b: 6'd0,  ci: 1'b0, exp_sum: 6'd0,  exp_cout: 1'b0};
        vecs[5] = '{a: 6'd21, b: 6'd42, ci: 1'b1, exp_sum: 6'd0,  exp_cout: 1'b1};
        vecs[6] = '{a: 6'd42, b: 6'd21, ci: 1'b0, exp_sum: 6'd63, exp_cout: 1'b0};

        rst_n = 1'b0;
        apply_stimulus(1'b0, 6'd0, 6'd0, 1'b0);
        model_reset();
        step();
        step();
        check_output("reset_sum", 32'(sum), 32'd0);
        check_output("reset_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            apply_stimulus(1'b1, vecs[i].a, vecs[i].b, vecs[i].ci);
            step();
            apply_stimulus(1'b0, 6'd0, 6'd0, 1'b0);
            for (int j = 0; j < LAT - 1; j++) step();
            check_output($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].exp_sum));
            check_output($sformatf("vec%0d_cout", i), 32'(cout), 32'(vecs[i].exp_cout));
            check_output($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            step();
        end

        // Hold: result stays while in_valid is low even though operands change.
        apply_stimulus(1'b1, 6'd5, 6'd6, 1'b0);
        step();
        apply_stimulus(1'b0, 6'd63, 6'd63, 1'b1);
        for (int j = 0; j < LAT; j++) step();
        check_output("hold_sum", 32'(sum), 32'd11);
        check_output("hold_cout", 32'(cout), 32'd0);
        check_output("hold_valid", 32'(out_valid), 32'd0);

        // Reset with in_valid high, in-flight data discarded.
        apply_stimulus(1'b1, 6'd40, 6'd30, 1'b1);
        step();
        rst_n = 1'b0;
        apply_stimulus(1'b1, 6'd50, 6'd20, 1'b0);
        step();
        check_output("rst_sum", 32'(sum), 32'd0);
        check_output("rst_cout", 32'(cout), 32'd0);
        check_output("rst_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        apply_stimulus(1'b0, 6'd0, 6'd0, 1'b0);
        for (int j = 0; j < LAT + 1; j++) begin
            step();
            check_output("post_rst_valid", 32'(out_valid), 32'd0);
            check_output("post_rst_sum", 32'(sum), 32'd0);
        end

        // Exhaustive back-to-back sweep, stopping at the first discrepancy.
        stop = 1'b0;
        for (int c = 0; c < 2 && !stop; c++) begin
            for (int x = 0; x < 64 && !stop; x++) begin
                for (int y = 0; y < 64 && !stop; y++) begin
                    apply_stimulus(1'b1, 6'(x), 6'(y), 1'(c));
                    step();
                    if (fail_count != 0) stop = 1'b1;
                end
            end
        end
        apply_stimulus(1'b0, 6'd0, 6'd0, 1'b0);
        for (int j = 0; j < LAT; j++) step();

        // Random traffic with sporadic resets.
        for (int n = 0; n < 500; n++) begin
            rst_n = ($urandom_range(0, 24) != 0);
            apply_stimulus(1'($urandom_range(0, 3) != 0), 6'($urandom), 6'($urandom),
                           1'($urandom));
            step();
        end
        rst_n = 1'b1;
        apply_stimulus(1'b0, 6'd0, 6'd0, 1'b0);
        for (int j = 0; j < LAT + 1; j++) step();

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
